mem_port_responder: RTL
=======================

# mem_port_responder

Services the pipeline's instruction-fetch (imem) and data (dmem) request ports over one shared, variable-latency memory interface. It is the responder for the read/resp handshake that the hazard unit and the IF/MEM stages rely on to stall. Sits between the IF/MEM stages and the physical memory (or cache). Arbitrates with dmem priority, registers all downstream and upstream outputs, and silently drains instruction fetches abandoned by a branch flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte mask width is DATA_W/8
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- imem_read_i  in  1  fetch request; held until imem_resp_o or withdrawn on flush
- imem_addr_i  in  ADDR_W  fetch address
- imem_resp_o  out  1  one-cycle fetch completion pulse
- imem_rdata_o  out  DATA_W  fetch data, valid with imem_resp_o, held after
- dmem_read_i, dmem_write_i  in  1 each  data request; held until dmem_resp_o
- dmem_addr_i  in  ADDR_W  data address
- dmem_wdata_i  in  DATA_W  store data
- dmem_wmask_i  in  DATA_W/8  store byte enables
- dmem_resp_o  out  1  one-cycle data completion pulse
- dmem_rdata_o  out  DATA_W  load data, valid with dmem_resp_o, held after
- mem_read_o, mem_write_o  out  1 each  downstream request, held until mem_resp_i
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W; mem_wmask_o  out  DATA_W/8
- mem_resp_i  in  1  downstream completion pulse
- mem_rdata_i  in  DATA_W  downstream read data, valid with mem_resp_i

## Operation
- States: IDLE, I_BUSY, D_BUSY, I_DRAIN, RESP.
- IDLE: dmem request wins over imem request. On grant, latch addr/wdata/wmask/kind into the downstream registers and enter D_BUSY or I_BUSY. If dmem_read_i and dmem_write_i are both high, it is a write.
- D_BUSY: hold the downstream request. A dmem request is never withdrawn, because the pipeline freezes. On mem_resp_i: capture mem_rdata_i into dmem_rdata_o (reads only; writes leave it unchanged), drop mem_read_o/mem_write_o, pulse dmem_resp_o, and enter RESP.
- I_BUSY: each cycle compare imem_read_i/imem_addr_i with the latched fetch. If imem_read_i is low or the address differs, the fetch is abandoned. On mem_resp_i with the fetch still valid: capture mem_rdata_i into imem_rdata_o, pulse imem_resp_o, and enter RESP.
- Abandoned fetch: if mem_resp_i arrives in the same cycle as the abandonment, discard the data and enter IDLE (no imem_resp_o). Otherwise enter I_DRAIN.
- I_DRAIN: keep mem_read_o asserted with the old address until mem_resp_i. Discard the data, raise no resp, and enter IDLE.
- RESP: one cycle; no new grant. This cycle lets the requester observe the resp and drop or advance its request. Then enter IDLE.
- The downstream request never changes address or kind while outstanding.
- Reset values: state IDLE; all *_resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o, imem_rdata_o, dmem_rdata_o = 0.
- Reset mid-transaction: the downstream request drops immediately. A mem_resp_i arriving after reset is ignored in IDLE.

## Timing
- Request first seen in IDLE at cycle N; mem_read_o/mem_write_o high from N+1.
- mem_resp_i at cycle M ≥ N+1; *_resp_o and *_rdata_o valid at M+1 (exactly one cycle).
- The next grant can occur at M+2 at the earliest. Best case: 2-cycle latency, 3-cycle issue interval.
- An imem request pending in IDLE while a dmem request is also pending waits through the full dmem transaction plus RESP.
- mem_resp_i while not in I_BUSY, D_BUSY or I_DRAIN is ignored.
- imem_resp_o and dmem_resp_o are never high together.

## Test plan
- Fetch, zero wait: imem_read_i=1, addr 0x100; mem_resp_i one cycle after mem_read_o with rdata 0x00000013. Required: mem_addr_o=0x100 at N+1, imem_resp_o=1 and imem_rdata_o=0x13 at N+3, one-cycle pulse.
- Load with 5-cycle memory latency: dmem_read_i, addr 0x2000; mem_resp_i 5 cycles after mem_read_o with data 0xDEADBEEF. Required: mem_read_o held 5 cycles; dmem_resp_o one cycle later; dmem_rdata_o=0xDEADBEEF held afterward.
- Simultaneous imem(0x104) and dmem write (0x3000, wdata 0xA5A5A5A5, mask 4'b0011). Required: the write is issued first with the exact mask and data. The fetch is issued in the cycle after the dmem RESP cycle. Two distinct resp pulses.
- Flush mid-fetch: fetch 0x200 outstanding; imem_read_i drops, then the new fetch at 0x300 appears before mem_resp_i. Required: mem_addr_o stays 0x200 until mem_resp_i, no imem_resp_o for 0x200, then 0x300 is issued and responded to with its own data.
- Flush coincident with mem_resp_i: no imem_resp_o; state returns to IDLE next cycle.
- Async reset while in D_BUSY: rst_ni low mid-cycle. Required: mem_write_o=0 immediately and all outputs 0. A stray mem_resp_i after release produces no resp pulse.

Source files
------------

// File: rtl/mem_port_responder_if.sv
// Signal bundle between the pipeline's imem/dmem ports, the responder and the shared memory.
// Names keep the responder's point of view: *_i are driven into it, *_o are driven by it.
interface mem_port_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises read/write with stable address/data and holds it until its
  // one-cycle resp pulse (an imem fetch may also be withdrawn on a flush); downstream the
  // responder holds mem_read/mem_write with stable address/data until the one-cycle mem_resp_i.
  logic                  imem_read_i;
  logic [ADDR_W-1:0]     imem_addr_i;
  logic                  imem_resp_o;
  logic [DATA_W-1:0]     imem_rdata_o;

  logic                  dmem_read_i;
  logic                  dmem_write_i;
  logic [ADDR_W-1:0]     dmem_addr_i;
  logic [DATA_W-1:0]     dmem_wdata_i;
  logic [DATA_W/8-1:0]   dmem_wmask_i;
  logic                  dmem_resp_o;
  logic [DATA_W-1:0]     dmem_rdata_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wmask_o;
  logic                  mem_resp_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  imem_read_i, imem_addr_i,
    output imem_resp_o, imem_rdata_o,
    input  dmem_read_i, dmem_write_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
    output dmem_resp_o, dmem_rdata_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_resp_i, mem_rdata_i
  );

  modport master (
    output imem_read_i, imem_addr_i,
    input  imem_resp_o, imem_rdata_o,
    output dmem_read_i, dmem_write_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
    input  dmem_resp_o, dmem_rdata_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_resp_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_responder.sv
// Arbitrates imem fetches and dmem accesses onto one variable-latency memory port (dmem first),
// with fully registered outputs and silent draining of fetches abandoned by a flush.
module mem_port_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  mem_port_responder_if.slave       bus,
  output logic [2:0]                dbg_state_o
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_I_BUSY  = 3'd1,
    S_D_BUSY  = 3'd2,
    S_I_DRAIN = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [MASK_W-1:0]   r_mem_wmask;
  logic                r_imem_resp;
  logic [DATA_W-1:0]   r_imem_rdata;
  logic                r_dmem_resp;
  logic [DATA_W-1:0]   r_dmem_rdata;

  logic                w_d_req;
  logic                w_i_abandon;

  assign w_d_req     = bus.dmem_read_i | bus.dmem_write_i;
  // The latched fetch stays wanted only while IF keeps presenting the same address.
  assign w_i_abandon = !bus.imem_read_i || (bus.imem_addr_i != r_mem_addr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_imem_resp  <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_resp  <= 1'b0;
      r_dmem_rdata <= '0;
    end else begin
      r_imem_resp <= 1'b0;
      r_dmem_resp <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_d_req) begin
            // A simultaneous read+write is treated as a store.
            r_mem_addr  <= bus.dmem_addr_i;
            r_mem_wdata <= bus.dmem_wdata_i;
            r_mem_wmask <= bus.dmem_wmask_i;
            r_mem_write <= bus.dmem_write_i;
            r_mem_read  <= ~bus.dmem_write_i;
            r_state     <= S_D_BUSY;
          end else if (bus.imem_read_i) begin
            r_mem_addr  <= bus.imem_addr_i;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_state     <= S_I_BUSY;
          end
        end
        S_D_BUSY: begin
          if (bus.mem_resp_i) begin
            if (!r_mem_write) begin
              r_dmem_rdata <= bus.mem_rdata_i;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_dmem_resp <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_I_BUSY: begin
          if (bus.mem_resp_i) begin
            r_mem_read <= 1'b0;
            if (w_i_abandon) begin
              r_state <= S_IDLE;
            end else begin
              r_imem_rdata <= bus.mem_rdata_i;
              r_imem_resp  <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (w_i_abandon) begin
            // Memory cannot cancel a read, so keep it outstanding and swallow its data.
            r_state <= S_I_DRAIN;
          end
        end
        S_I_DRAIN: begin
          if (bus.mem_resp_i) begin
            r_mem_read <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read_o   = r_mem_read;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wdata_o  = r_mem_wdata;
  assign bus.mem_wmask_o  = r_mem_wmask;
  assign bus.imem_resp_o  = r_imem_resp;
  assign bus.imem_rdata_o = r_imem_rdata;
  assign bus.dmem_resp_o  = r_dmem_resp;
  assign bus.dmem_rdata_o = r_dmem_rdata;
  assign dbg_state_o      = r_state;

endmodule
